// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared constants and state encoding for the PC sequencer.
package pc_sequencer_pkg;

  localparam int XLEN = 32;

  // Canonical NOP (addi x0, x0, 0) that flushed pipeline registers hold
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } seq_state_t;

  // Clears the two low address bits so that a fetch address is always word aligned
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             INC,
  output logic [WIDTH-1:0] COUNT
);

  logic [WIDTH-1:0] count_reg;

  // Count enabled cycles; once full, further increments are dropped
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      count_reg <= '0;
    end else if (INC && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign COUNT = count_reg;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address sequencer and pipeline enable/flush control.
// Holds fetch for HOLD_CYCLES after reset, then steps PC by 4, handling global
// stalls, load-use bubbles and EX redirects.
// Optional feature macro: PC_SEQ_TRAP_EN (misaligned redirects trap to TRAP_VECTOR).
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              HOLD_CYCLES  = 2,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            IMEM_BUSYWAIT,
  input  logic            DMEM_BUSYWAIT,
  input  logic            MULDIV_BUSY,
  input  logic            LOAD_USE,
  input  logic            BRANCH_TAKEN,
  input  logic [XLEN-1:0] BRANCH_TARGET,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_PLUS4,
  output logic            IFID_EN,
  output logic            IDEX_EN,
  output logic            IFID_FLUSH,
  output logic            IDEX_FLUSH,
  output logic [15:0]     STALL_CNT,
  output logic            MISALIGN_EXC
);

  seq_state_t      state_reg, state_next;
  logic [3:0]      hold_cnt_reg, hold_cnt_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] redirect_pc;
  logic            misaligned;
  logic            misalign_next;
  logic            gs;
  logic            stall_inc;

  assign gs = IMEM_BUSYWAIT | DMEM_BUSYWAIT | MULDIV_BUSY;

`ifdef PC_SEQ_TRAP_EN
  assign misaligned  = (BRANCH_TARGET[1:0] != 2'b00);
  assign redirect_pc = misaligned ? TRAP_VECTOR : BRANCH_TARGET;
`else
  assign misaligned  = 1'b0;
  assign redirect_pc = word_align(BRANCH_TARGET);
  // Constants and target bits with no consumer when trapping is disabled
  logic unused_cfg;
  assign unused_cfg = ^{TRAP_VECTOR, NOP_INSTR, BRANCH_TARGET[1:0]};
`endif

  // Next-state and output decode; a stall overrides RUN in the same cycle,
  // and a STALL with the stall source gone behaves as RUN for that edge
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    pc_next       = pc_reg;
    misalign_next = 1'b0;
    stall_inc     = 1'b0;
    IFID_EN       = 1'b0;
    IDEX_EN       = 1'b0;
    IFID_FLUSH    = 1'b0;
    IDEX_FLUSH    = 1'b0;
    case (state_reg)
      HOLD: begin
        IFID_FLUSH = 1'b1;
        IDEX_FLUSH = 1'b1;
        pc_next    = RESET_VECTOR;
        if (hold_cnt_reg == 4'(HOLD_CYCLES - 1)) begin
          state_next    = RUN;
          hold_cnt_next = 4'd0;
        end else begin
          hold_cnt_next = hold_cnt_reg + 4'd1;
        end
      end
      RUN, STALL: begin
        if (gs) begin
          state_next = STALL;
          stall_inc  = 1'b1;
        end else begin
          state_next = RUN;
          if (BRANCH_TAKEN) begin
            pc_next       = redirect_pc;
            misalign_next = misaligned;
            IFID_EN       = 1'b1;
            IDEX_EN       = 1'b1;
            IFID_FLUSH    = 1'b1;
            IDEX_FLUSH    = 1'b1;
          end else if (LOAD_USE) begin
            IDEX_EN    = 1'b1;
            IDEX_FLUSH = 1'b1;
          end else begin
            pc_next = pc_reg + 32'd4;
            IFID_EN = 1'b1;
            IDEX_EN = 1'b1;
          end
        end
      end
      default: begin
        state_next    = HOLD;
        hold_cnt_next = 4'd0;
      end
    endcase
  end

  // State, hold counter and PC registers; reset restarts the hold sequence
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_reg    <= HOLD;
      hold_cnt_reg <= 4'd0;
      pc_reg       <= RESET_VECTOR;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      pc_reg       <= pc_next;
    end
  end

`ifdef PC_SEQ_TRAP_EN
  logic misalign_reg;

  // One-cycle exception pulse accompanying a trapped redirect
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= misalign_next;
    end
  end

  assign MISALIGN_EXC = misalign_reg;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_next;
  assign MISALIGN_EXC    = 1'b0;
`endif

  sat_counter #(
    .WIDTH(16)
  ) u_stall_cnt (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .INC  (stall_inc),
    .COUNT(STALL_CNT)
  );

  assign PC       = pc_reg;
  assign PC_PLUS4 = pc_reg + 32'd4;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized traffic against a
// cycle-level reference model of the fetch sequencing rules.
module tb_pc_sequencer;

  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] TRAP = 32'h0000_0100;
  localparam int          HC   = 2;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic        DMEM_BUSYWAIT = 1'b0;
  logic        MULDIV_BUSY = 1'b0;
  logic        LOAD_USE = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'h0;
  logic [31:0] PC, PC_PLUS4;
  logic        IFID_EN, IDEX_EN, IFID_FLUSH, IDEX_FLUSH;
  logic [15:0] STALL_CNT;
  logic        MISALIGN_EXC;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state
  logic [31:0] m_pc;
  int          m_hold_left;
  logic [15:0] m_cnt;
  logic        m_exc;

  pc_sequencer #(
    .RESET_VECTOR(RV),
    .HOLD_CYCLES (HC),
    .TRAP_VECTOR (TRAP)
  ) dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
    .MULDIV_BUSY  (MULDIV_BUSY),
    .LOAD_USE     (LOAD_USE),
    .BRANCH_TAKEN (BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET),
    .PC           (PC),
    .PC_PLUS4     (PC_PLUS4),
    .IFID_EN      (IFID_EN),
    .IDEX_EN      (IDEX_EN),
    .IFID_FLUSH   (IFID_FLUSH),
    .IDEX_FLUSH   (IDEX_FLUSH),
    .STALL_CNT    (STALL_CNT),
    .MISALIGN_EXC (MISALIGN_EXC)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc        = RV;
    m_hold_left = HC;
    m_cnt       = 16'h0;
    m_exc       = 1'b0;
  endtask

  // Entered 1 time unit after a rising edge; pulses RESET mid-cycle
  task automatic do_reset();
    #2 RESET = 1'b1;
    #1;
    check("rst_pc", PC, RV);
    check("rst_cnt", 32'(STALL_CNT), 32'h0);
    check("rst_exc", 32'(MISALIGN_EXC), 32'h0);
    IMEM_BUSYWAIT = 1'b0; DMEM_BUSYWAIT = 1'b0; MULDIV_BUSY = 1'b0;
    LOAD_USE = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0;
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    model_reset();
    $display("[TB] reset pulse released at cycle %0d", cyc);
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, then
  // advance the model across the rising edge
  task automatic cycle(input logic ib, input logic db, input logic md,
                       input logic lu, input logic bt, input logic [31:0] tgt);
    logic       gsv;
    logic [3:0] ctl;
    IMEM_BUSYWAIT = ib; DMEM_BUSYWAIT = db; MULDIV_BUSY = md;
    LOAD_USE = lu; BRANCH_TAKEN = bt; BRANCH_TARGET = tgt;
    gsv = ib | db | md;
    // expected {IFID_EN, IDEX_EN, IFID_FLUSH, IDEX_FLUSH}
    if (m_hold_left > 0) ctl = 4'b0011;
    else if (gsv)        ctl = 4'b0000;
    else if (bt)         ctl = 4'b1111;
    else if (lu)         ctl = 4'b0101;
    else                 ctl = 4'b1100;
    @(negedge CLOCK);
    check("pc", PC, m_pc);
    check("pc_plus4", PC_PLUS4, m_pc + 32'd4);
    check("ctl", 32'({IFID_EN, IDEX_EN, IFID_FLUSH, IDEX_FLUSH}), 32'(ctl));
    check("stall_cnt", 32'(STALL_CNT), 32'(m_cnt));
    check("misalign", 32'(MISALIGN_EXC), 32'(m_exc));
    $display("[TB] cyc %0d in=%b%b%b%b%b tgt=%h pc=%h ctl=%b%b%b%b cnt=%0d exc=%b",
             cyc, ib, db, md, lu, bt, tgt, PC, IFID_EN, IDEX_EN, IFID_FLUSH, IDEX_FLUSH,
             STALL_CNT, MISALIGN_EXC);
    @(posedge CLOCK); #1;
    cyc++;
    m_exc = 1'b0;
    if (m_hold_left > 0) begin
      m_hold_left--;
      m_pc = RV;
    end else if (gsv) begin
      if (m_cnt != 16'hFFFF) m_cnt++;
    end else if (bt) begin
`ifdef PC_SEQ_TRAP_EN
      if (tgt % 4 != 0) begin
        m_pc  = TRAP;
        m_exc = 1'b1;
      end else begin
        m_pc = tgt;
      end
`else
      m_pc = tgt - (tgt % 4);
`endif
    end else if (!lu) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Free-run until the model reaches addr, bounded
  task automatic run_to(input logic [31:0] addr);
    for (int i = 0; i < 64 && m_pc != addr; i++) idle();
    check("run_to", PC, addr);
  endtask

  initial begin
    logic [31:0] pc_snap;
    logic [31:0] rtgt;
    model_reset();
    @(posedge CLOCK); #1;
    do_reset();

    // Hold sequence, then PC steps 0, 4, 8
    idle(); idle();
    check("boot_pc0", PC, 32'h0);
    idle();
    check("boot_pc4", PC, 32'h4);
    idle();
    check("boot_pc8", PC, 32'h8);

    // Data-memory stall for three cycles at 0x10
    run_to(32'h10);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("stall_pc", PC, 32'h10);
    check("stall_cnt3", 32'(STALL_CNT), 32'd3);
    idle();
    check("stall_resume", PC, 32'h14);

    // Load-use bubble at 0x20
    run_to(32'h20);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("lu_hold", PC, 32'h20);
    idle();
    check("lu_resume", PC, 32'h24);

    // Branch wins over load-use
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
    check("br_lu", PC, 32'h80);

    // Branch held behind an instruction-memory stall
    pc_snap = PC;
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    check("br_stall_hold", PC, pc_snap);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    check("br_after_stall", PC, 32'h40);

    // Misaligned redirect
    idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h42);
`ifdef PC_SEQ_TRAP_EN
    check("misalign_pc", PC, 32'h100);
    check("misalign_pulse", 32'(MISALIGN_EXC), 32'd1);
`else
    check("misalign_pc", PC, 32'h40);
    check("misalign_pulse", 32'(MISALIGN_EXC), 32'd0);
`endif
    idle();
    check("misalign_clear", 32'(MISALIGN_EXC), 32'd0);

    // Wrap from the top of the address space
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    idle();
    check("wrap", PC, 32'h0);

    // Reset in the middle of a stall with a pending branch
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
    do_reset();
    idle(); idle(); idle();
    check("post_rst_pc", PC, 32'h4);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        rtgt = $urandom;
        if ($urandom_range(0, 1) == 1) rtgt[1:0] = 2'b00;
        cycle($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 7) == 0, rtgt);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2, the number of cycles fetch is held after reset release (range 1..15).
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, used only when PC_SEQ_TRAP_EN is defined.
REQ-004 SHALL have ports (one per line: name, direction, width, meaning):
  CLOCK  in  1  single clock, rising edge.
  RESET  in  1  asynchronous, active-high reset.
  IMEM_BUSYWAIT  in  1  instruction memory not ready.
  DMEM_BUSYWAIT  in  1  data memory not ready.
  MULDIV_BUSY  in  1  multi-cycle M-extension unit busy.
  LOAD_USE  in  1  load-use hazard detected in ID.
  BRANCH_TAKEN  in  1  EX resolved a taken branch or jump.
  BRANCH_TARGET  in  32  redirect address from EX.
  PC  out  32  current fetch address, registered.
  PC_PLUS4  out  32  PC + 4, combinational.
  IFID_EN  out  1  IF/ID register write enable.
  IDEX_EN  out  1  ID/EX, EX/MEM and MEM/WB register write enable.
  IFID_FLUSH  out  1  IF/ID register clear to NOP.
  IDEX_FLUSH  out  1  ID/EX register clear to NOP.
  STALL_CNT  out  16  saturating count of global-stall cycles.
  MISALIGN_EXC  out  1  one-cycle pulse on a misaligned redirect (tied 0 without the macro).

Function
REQ-005 SHALL implement states HOLD, RUN, STALL.
REQ-006 In HOLD, a 4-bit counter SHALL count up each cycle, and the block SHALL go to RUN when the count reaches HOLD_CYCLES-1.
REQ-007 In HOLD, PC SHALL stay at RESET_VECTOR, IFID_EN and IDEX_EN SHALL be 0, and IFID_FLUSH and IDEX_FLUSH SHALL be 1.
REQ-008 The global stall signal GS SHALL be defined as IMEM_BUSYWAIT | DMEM_BUSYWAIT | MULDIV_BUSY.
REQ-009 From RUN with GS=1, the block SHALL enter STALL in the same cycle, combinationally.
REQ-010 While GS=1, PC SHALL hold, all enables SHALL be 0, and all flushes SHALL be 0.
REQ-011 From STALL with GS=0, the block SHALL return to RUN on the next edge.
REQ-012 In RUN with GS=0, BRANCH_TAKEN=1 SHALL have the highest priority: PC <= BRANCH_TARGET, IFID_FLUSH=1, IDEX_FLUSH=1, and IFID_EN=IDEX_EN=1.
REQ-013 In RUN with GS=0, BRANCH_TAKEN=0 and LOAD_USE=1, PC SHALL hold, IFID_EN SHALL be 0, IDEX_FLUSH SHALL be 1, and IDEX_EN SHALL be 1.
REQ-014 Otherwise in RUN, PC <= PC+4 and IFID_EN=IDEX_EN=1, with no flush.
REQ-015 A BRANCH_TAKEN raised during GS SHALL be ignored until GS falls; EX is frozen, so BRANCH_TAKEN and BRANCH_TARGET remain stable and the redirect applies on the first non-stalled edge.
REQ-016 PC arithmetic SHALL be modulo 2^32: PC=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-017 STALL_CNT SHALL increment on every edge with GS=1 outside HOLD, and SHALL saturate at 16'hFFFF.
REQ-018 Redirect latency SHALL be one edge: the target appears on PC in the cycle after BRANCH_TAKEN is sampled.

Reset
REQ-019 While RESET=1, asynchronously: state=HOLD, counter=0, PC=RESET_VECTOR, STALL_CNT=0, MISALIGN_EXC=0.
REQ-020 A RESET asserted mid-stall or mid-redirect SHALL discard the pending operation, and the HOLD sequence SHALL restart after release.

Configuration
REQ-021 With PC_SEQ_TRAP_EN defined, a redirect with BRANCH_TARGET[1:0]!=0 SHALL load TRAP_VECTOR instead of the target, SHALL pulse MISALIGN_EXC for one cycle, and SHALL still flush both registers.
REQ-022 Without PC_SEQ_TRAP_EN, BRANCH_TARGET[1:0] SHALL be forced to 0 and MISALIGN_EXC SHALL be constant 0.

Structure
REQ-023 A shared package SHALL hold the state encoding (HOLD=2'd0, RUN=2'd1, STALL=2'd2), the XLEN=32 constant and the NOP instruction constant 32'h0000_0013.
REQ-024 The state register, next-state logic and output decode SHALL be in one module with no sub-modules; STALL_CNT MAY be a sub-module sat_counter.

Verification
REQ-025 The bench SHALL cover: RESET pulse, HOLD_CYCLES=2 -> PC=0, flushes=1 for 2 cycles, then PC steps 0, 4, 8.
REQ-026 The bench SHALL cover: DMEM_BUSYWAIT=1 for 3 cycles at PC=0x10 -> PC stays 0x10, enables=0, STALL_CNT=3, then PC=0x14.
REQ-027 The bench SHALL cover: LOAD_USE=1 for 1 cycle at PC=0x20 -> PC stays 0x20 for one cycle, IDEX_FLUSH=1, IFID_EN=0.
REQ-028 The bench SHALL cover: BRANCH_TAKEN=1 and LOAD_USE=1 together, target 0x80 -> PC=0x80 next cycle, both flushes=1.
REQ-029 The bench SHALL cover: BRANCH_TAKEN=1 during IMEM_BUSYWAIT for 2 cycles, target 0x40 -> PC holds, then PC=0x40 one edge after the busywait clears.
REQ-030 The bench SHALL cover, with PC_SEQ_TRAP_EN: target 0x42 -> PC=0x100, MISALIGN_EXC pulses once; without the macro -> PC=0x40.
